// File: rtl/vproc_mul_seq32.sv
// Sequences one 32x32 multiply through a single 17x17 signed multiplier block:
// four partial products issued back to back, accumulated into a 64-bit product.
module vproc_mul_seq32 #(
   parameter int unsigned MUL_LATENCY = 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [31:0]        in_op1_i,
   input  logic [31:0]        in_op2_i,
   input  logic               in_op1_signed_i,
   input  logic               in_op2_signed_i,
   input  logic               in_high_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [31:0]        out_res_o,
   output logic signed [16:0] mul_op1_o,
   output logic signed [16:0] mul_op2_o,
   input  logic signed [32:0] mul_res_i
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   // A latency of zero still keeps one (unused) tag stage so the vectors stay legal.
   localparam int unsigned DEPTH = (MUL_LATENCY == 0) ? 1 : MUL_LATENCY;

   state_t             state_q, state_d;
   logic [1:0]         cnt_q;
   logic [31:0]        op1_q, op2_q;
   logic               op1_signed_q, op2_signed_q, high_q;
   logic signed [63:0] acc_q;
   logic [DEPTH-1:0]   vld_p;
   logic [1:0]         k_p [DEPTH];
   logic               accept, iss_vld, col_vld;
   logic [1:0]         col_k;

   // Low halves are always unsigned; high halves carry the operand's sign bit.
   function automatic logic signed [16:0] ext_half(input logic [31:0] a, input logic sgn,
                                                   input logic hi);
      return hi ? {sgn & a[31], a[31:16]} : {1'b0, a[15:0]};
   endfunction

   function automatic logic signed [63:0] align_pp(input logic signed [32:0] res,
                                                   input logic [1:0] k);
      logic signed [63:0] ext;
      ext = {{31{res[32]}}, res};
      case (k)
         2'd0:    return ext;
         2'd3:    return ext <<< 32;
         default: return ext <<< 16;
      endcase
   endfunction

   assign accept  = (state_q == IDLE) && in_valid_i;
   assign iss_vld = (state_q == ISSUE);

   always_comb begin
      if (MUL_LATENCY == 0) begin
         col_vld = iss_vld;
         col_k   = cnt_q;
      end else begin
         col_vld = vld_p[DEPTH-1];
         col_k   = k_p[DEPTH-1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (in_valid_i) state_d = ISSUE;
         ISSUE: if (cnt_q == 2'd3) state_d = (col_vld && col_k == 2'd3) ? DONE : DRAIN;
         DRAIN: if (col_vld && col_k == 2'd3) state_d = DONE;
         DONE:  if (out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      out_res_o   = '0;
      mul_op1_o   = '0;
      mul_op2_o   = '0;
      case (state_q)
         IDLE:  in_ready_o = 1'b1;
         ISSUE: begin
            mul_op1_o = ext_half(op1_q, op1_signed_q, cnt_q[1]);
            mul_op2_o = ext_half(op2_q, op2_signed_q, cnt_q[0]);
         end
         DONE: begin
            out_valid_o = 1'b1;
            out_res_o   = high_q ? acc_q[63:32] : acc_q[31:0];
         end
         default: ;
      endcase
   end

   // Issue stage: operand capture
   always_ff @(posedge clk_i) begin
      if (accept) begin
         op1_q        <= in_op1_i;
         op2_q        <= in_op2_i;
         op1_signed_q <= in_op1_signed_i;
         op2_signed_q <= in_op2_signed_i;
         high_q       <= in_high_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= '0;
      end else if (iss_vld) begin
         cnt_q <= cnt_q + 2'd1;
      end
   end

   // Tag stages: mirror the multiplier latency so only issued products are collected
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_p <= '0;
         for (int i = 0; i < DEPTH; i++) k_p[i] <= '0;
      end else begin
         vld_p[0] <= iss_vld;
         k_p[0]   <= cnt_q;
         for (int i = 1; i < DEPTH; i++) begin
            vld_p[i] <= vld_p[i-1];
            k_p[i]   <= k_p[i-1];
         end
      end
   end

   // Collect stage: the multiplier block has no reset, so untagged results are dropped
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
      end else if (accept) begin
         acc_q <= '0;
      end else if (col_vld) begin
         acc_q <= acc_q + align_pp(mul_res_i, col_k);
      end
   end

endmodule
